// File: rtl/led_scan_driver.sv
// led_scan_driver
//   Row-scan reader for the 8x8 bicolour LED frame buffer. Walks the buffer
//   one row at a time over a one-hot row/col read address, decodes each
//   4-bit pixel into red/green column drive and lights one matrix row at a
//   time for DWELL_CYCLES clocks. The next row is prefetched into shadow
//   registers during the current row's dwell, so only the very first row
//   after enable pays for a fetch.
//
//   Optional feature: define LED_SCAN_BLANK_EN to insert BLANK_CYCLES dark
//   clocks between rows (anti-ghosting gap).
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   scan_en       1 = scan runs, 0 = display dark and scanner idle
//   ram_addr_row  one-hot row read address to the frame buffer
//   ram_addr_col  one-hot column read address to the frame buffer
//   ram_data      pixel: [3] stored, [2] green, [1] red, [0] unused
//   row_on        one-hot row drive, all-zero = dark
//   col_r/col_g   red/green column drive, bit c = column c
//   frame_start   one-clock pulse on the first lit cycle of row 0
module led_scan_driver #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  output logic [7:0] ram_addr_row,
  output logic [7:0] ram_addr_col,
  input  logic [3:0] ram_data,
  output logic [7:0] row_on,
  output logic [7:0] col_r,
  output logic [7:0] col_g,
  output logic       frame_start
);

`ifdef LED_SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, FETCH, SHOW, BLANK} state_t;
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
`else
  typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;
  localparam int unused_blank_cycles = BLANK_CYCLES;
`endif

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  // ram_data[0] carries no information for the display
  logic unused_data_bit;
  assign unused_data_bit = ram_data[0];

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'h01 << idx;
  endfunction

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;        // FETCH index k, SHOW dwell d, BLANK count
  logic [2:0]  ptr, ptr_nxt;        // row currently shown (or being fetched)
  logic [7:0]  sh_r, sh_r_nxt;      // shadow of the next row's column drive
  logic [7:0]  sh_g, sh_g_nxt;
  logic [7:0]  addr_row_nxt, addr_col_nxt;
  logic [7:0]  row_on_nxt, col_r_nxt, col_g_nxt;
  logic        frame_start_nxt;

  logic        capture;
  logic [2:0]  cap_idx;
  logic        dec_r, dec_g;
  logic        show_go;
  logic [2:0]  show_ptr;

  // Pixel decode: an unstored pixel is off whatever its colour bits say
  assign dec_r   = ram_data[3] & ram_data[1];
  assign dec_g   = ram_data[3] & ram_data[2];
  // Data for the column addressed in cycle k arrives in cycle k+1
  assign cap_idx = cnt[2:0] - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= '0;
      sh_r         <= '0;
      sh_g         <= '0;
      ram_addr_row <= 8'h01;
      ram_addr_col <= 8'h01;
      row_on       <= '0;
      col_r        <= '0;
      col_g        <= '0;
      frame_start  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ptr          <= ptr_nxt;
      sh_r         <= sh_r_nxt;
      sh_g         <= sh_g_nxt;
      ram_addr_row <= addr_row_nxt;
      ram_addr_col <= addr_col_nxt;
      row_on       <= row_on_nxt;
      col_r        <= col_r_nxt;
      col_g        <= col_g_nxt;
      frame_start  <= frame_start_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    ptr_nxt         = ptr;
    sh_r_nxt        = sh_r;
    sh_g_nxt        = sh_g;
    addr_row_nxt    = ram_addr_row;
    addr_col_nxt    = ram_addr_col;
    row_on_nxt      = row_on;
    col_r_nxt       = col_r;
    col_g_nxt       = col_g;
    frame_start_nxt = 1'b0;
    show_go         = 1'b0;
    show_ptr        = ptr;

    // Columns are captured in cycles 1..8 of both the initial fill and the
    // in-dwell prefetch; the addressing pattern is the same in both.
    capture = ((state == FETCH) || (state == SHOW)) &&
              (cnt >= 16'd1) && (cnt <= 16'd8);
    if (capture) begin
      sh_r_nxt[cap_idx] = dec_r;
      sh_g_nxt[cap_idx] = dec_g;
    end

    case (state)
      IDLE: begin
        if (scan_en) begin
          state_nxt    = FETCH;
          cnt_nxt      = '0;
          ptr_nxt      = '0;
          addr_row_nxt = onehot(3'd0);
          addr_col_nxt = onehot(3'd0);
        end
      end
      FETCH: begin
        if (cnt == 16'd8) begin
          show_go  = 1'b1;
          show_ptr = ptr;
        end else begin
          cnt_nxt = cnt + 16'd1;
          if (cnt < 16'd7) addr_col_nxt = onehot(cnt[2:0] + 3'd1);
        end
      end
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          ptr_nxt = ptr + 3'd1;
`ifdef LED_SCAN_BLANK_EN
          state_nxt  = BLANK;
          cnt_nxt    = '0;
          row_on_nxt = '0;
          col_r_nxt  = '0;
          col_g_nxt  = '0;
`else
          show_go  = 1'b1;
          show_ptr = ptr + 3'd1;
`endif
        end else begin
          cnt_nxt = cnt + 16'd1;
          // prefetch addressing runs d=0..7, then holds
          if (cnt < 16'd7) addr_col_nxt = onehot(cnt[2:0] + 3'd1);
        end
      end
`ifdef LED_SCAN_BLANK_EN
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          show_go  = 1'b1;
          show_ptr = ptr;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // Entering SHOW: shadow (including the column captured this very
    // cycle) goes to the pins and the prefetch of the following row starts.
    if (show_go) begin
      state_nxt       = SHOW;
      cnt_nxt         = '0;
      row_on_nxt      = onehot(show_ptr);
      col_r_nxt       = sh_r_nxt;
      col_g_nxt       = sh_g_nxt;
      addr_row_nxt    = onehot(show_ptr + 3'd1);
      addr_col_nxt    = onehot(3'd0);
      frame_start_nxt = (show_ptr == 3'd0);
    end

    if (!scan_en) begin
      state_nxt       = IDLE;
      cnt_nxt         = '0;
      ptr_nxt         = '0;
      row_on_nxt      = '0;
      col_r_nxt       = '0;
      col_g_nxt       = '0;
      frame_start_nxt = 1'b0;
      addr_row_nxt    = 8'h01;
      addr_col_nxt    = 8'h01;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
module tb_led_scan_driver;
  localparam int DWELL = 16;
  localparam int BLANK = 4;
`ifdef LED_SCAN_BLANK_EN
  localparam int GAP = BLANK;
`else
  localparam int GAP = 0;
`endif
  localparam int PERIOD = DWELL + GAP;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic [7:0] ram_addr_row, ram_addr_col;
  logic [3:0] ram_data = 4'h0;
  logic [7:0] row_on, col_r, col_g;
  logic       frame_start;

  led_scan_driver #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en),
    .ram_addr_row(ram_addr_row), .ram_addr_col(ram_addr_col),
    .ram_data(ram_data), .row_on(row_on), .col_r(col_r), .col_g(col_g),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] row;
    logic [7:0] r;
    logic [7:0] g;
    logic       fs;
    int         dark;   // dark samples before this row, -1 = don't care
  } exp_t;

  exp_t       q[$];
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  logic [3:0] mem [0:7][0:7];
  logic [7:0] exp_r [0:7];
  logic [7:0] exp_g [0:7];

  function automatic int oh2i(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read frame buffer: address seen at an edge, data next cycle
  always @(posedge clk) ram_data <= mem[oh2i(ram_addr_row)][oh2i(ram_addr_col)];

  // Monitor: a row lighting up (or a frame_start) is the DUT's output event
  logic [7:0] prev_row = 8'h00;
  int         dark_run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      logic ev;
      ev = (row_on != 8'h00) && (row_on != prev_row);
      if (ev) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_row cyc=%0d row_on=%h (nothing expected)", cyc, row_on);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cyc != e.cyc || row_on != e.row || col_r != e.r || col_g != e.g ||
              frame_start != e.fs || (e.dark >= 0 && dark_run != e.dark)) begin
            mismatched++;
            $display("FAIL row_event got cyc=%0d row=%h r=%h g=%h fs=%b dark=%0d expected cyc=%0d row=%h r=%h g=%h fs=%b dark=%0d",
                     cyc, row_on, col_r, col_g, frame_start, dark_run,
                     e.cyc, e.row, e.r, e.g, e.fs, e.dark);
          end
        end
      end
      if (frame_start && !(ev && row_on == 8'h01)) begin
        compared++;
        mismatched++;
        $display("FAIL frame_start_stray cyc=%0d row_on=%h expected pulse only on first row-0 cycle", cyc, row_on);
      end
      dark_run = (row_on == 8'h00) ? dark_run + 1 : 0;
      prev_row = row_on;
    end else begin
      dark_run = 0;
      prev_row = 8'h00;
    end
  end

  task automatic check_idle(input string name);
    compared++;
    if (row_on !== 8'h00 || col_r !== 8'h00 || col_g !== 8'h00 || frame_start !== 1'b0 ||
        ram_addr_row !== 8'h01 || ram_addr_col !== 8'h01) begin
      mismatched++;
      $display("FAIL %s got row=%h r=%h g=%h fs=%b ar=%h ac=%h expected 00 00 00 0 01 01",
               name, row_on, col_r, col_g, frame_start, ram_addr_row, ram_addr_col);
    end
  endtask

  task automatic push_row(input int t, input int n, input int dark);
    exp_t e;
    e.cyc  = t;
    e.row  = 8'h01 << (n % 8);
    e.r    = exp_r[n % 8];
    e.g    = exp_g[n % 8];
    e.fs   = ((n % 8) == 0);
    e.dark = dark;
    q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t0, ta, t1, lim;
    rst = 1'b1;
    scan_en = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[r][c] = 4'h0;
    mem[2][5] = 4'b1010;   // red col 5
    mem[0][0] = 4'b0110;   // not stored -> off
    mem[0][1] = 4'b1100;   // green col 1
    mem[3][3] = 4'b1111;   // both, bit 0 ignored
    mem[5][7] = 4'b1110;   // both on the last column
    mem[6][6] = 4'b0010;   // not stored -> off
    mem[7][0] = 4'b1001;   // stored, no colour -> off
    // hand-decoded rows
    exp_r[0] = 8'h00; exp_g[0] = 8'h02;
    exp_r[1] = 8'h00; exp_g[1] = 8'h00;
    exp_r[2] = 8'h20; exp_g[2] = 8'h00;
    exp_r[3] = 8'h08; exp_g[3] = 8'h08;
    exp_r[4] = 8'h00; exp_g[4] = 8'h00;
    exp_r[5] = 8'h80; exp_g[5] = 8'h80;
    exp_r[6] = 8'h00; exp_g[6] = 8'h00;
    exp_r[7] = 8'h00; exp_g[7] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_idle("idle_scan_off");
    end

    // Free run: 3 frames plus the wrap back to row 0, then rows 1..3
    t0 = cyc;
    scan_en = 1'b1;
    for (int n = 0; n < 28; n++) push_row(t0 + 10 + n * PERIOD, n, (n == 0) ? -1 : GAP);

    // Drop scan_en so that it is seen at the end of d=5 of row 3
    ta = t0 + 10 + 27 * PERIOD;
    wait_until(ta + 5);
    scan_en = 1'b0;
    @(posedge clk);
    #1;
    check_idle("dark_after_disable");
    repeat (6) @(posedge clk);
    #1;
    check_idle("idle_while_disabled");

    t1 = cyc;
    scan_en = 1'b1;
    push_row(t1 + 10, 0, -1);
    push_row(t1 + 10 + PERIOD, 1, GAP);

    lim = t1 + 10 + PERIOD + 40;
    while (q.size() != 0 && cyc < lim) begin
      @(posedge clk);
      #1;
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d rows outstanding expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Row-scan reader for the 8x8 bicolour LED frame buffer: walks the buffer one row at a time over its one-hot row/col read address port, decodes each 4-bit pixel into red/green column drive, and drives one matrix row at a time for a fixed dwell. It sits between the LED frame buffer and the matrix pins. The light-pen path is the buffer's writer; this block only reads. Its next row is prefetched during the current row's dwell, so the display never goes dark for a fetch, except at start-up.

## Interface
- DWELL_CYCLES, 1000: clocks each row is lit; legal range 10..65535.
- BLANK_CYCLES, 4: all-rows-off clocks between rows (only with LED_SCAN_BLANK_EN); legal range 1..255.
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- scan_en  in  1  1 = scan runs; 0 = display off, scanner idle
- ram_addr_row  out  8  one-hot row read address to frame buffer
- ram_addr_col  out  8  one-hot column read address to frame buffer
- ram_data  in  4  pixel from frame buffer: [3] stored, [2] G, [1] R, [0] unused
- row_on  out  8  one-hot active-high row drive; all-zero = dark
- col_r  out  8  red column drive, bit c = column c
- col_g  out  8  green column drive
- frame_start  out  1  one-clock pulse on the first lit cycle of row 0

## Operation
- States: IDLE, FETCH, SHOW, BLANK (BLANK exists only with the macro).
- IDLE: outputs dark. When scan_en=1, move to FETCH with row pointer 0.
- FETCH is the initial fill and lasts 9 cycles (index k=0..8).
  - For k=0..7, drive ram_addr_row = one-hot(row pointer) and ram_addr_col = one-hot(k).
  - For k=1..8, capture ram_data for column k-1 into the shadow R/G registers.
  - Then go to SHOW.
- Pixel decode: R = ram_data[3] & ram_data[1]; G = ram_data[3] & ram_data[2]. A pixel with [3]=0 is off regardless of [2:1]. Bit [0] is ignored.
- Entering SHOW: the shadow registers load into col_r/col_g, and row_on becomes one-hot(row pointer).
- SHOW lasts DWELL_CYCLES cycles (dwell counter d=0..DWELL_CYCLES-1).
  - During d=0..8, prefetch row (pointer+1) mod 8 into the shadow registers using the FETCH addressing pattern.
  - For d>8, addresses hold their last value.
- At d=DWELL_CYCLES-1:
  - The row pointer increments modulo 8; 7 wraps to 0.
  - The next state is BLANK with the macro, otherwise SHOW of the new row.
- The frame buffer is not snooped: a write to a pixel after its prefetch appears on the next frame.
- scan_en=0 in any state: next cycle goes to IDLE.
  - row_on, col_r and col_g are 0; the row pointer clears to 0.
  - Re-enabling always restarts with FETCH of row 0.
- The block never writes the buffer and has no write-enable output.

## Timing
- Values on rst: state IDLE, row_on=0, col_r=0, col_g=0, frame_start=0, ram_addr_row=8'h01, ram_addr_col=8'h01, all counters and shadows 0.
- All outputs are registered.
- Read latency: an address driven in cycle k gives data sampled in cycle k+1.
- Latency from scan_en rising to row 0 lit: 10 clocks (1 IDLE exit + 9 FETCH).
- Row period is DWELL_CYCLES, plus BLANK_CYCLES with the macro. Frame period is 8 × row period.
- frame_start pulses for exactly one cycle, coincident with the first SHOW cycle of row 0, including the first row 0 after enable.
- rst asserted mid-frame forces the reset values asynchronously. After rst is released with scan_en=1, the scan behaves as a fresh enable.

## Configuration
- LED_SCAN_BLANK_EN defined:
  - After each SHOW, BLANK holds row_on=0, col_r=0 and col_g=0 for BLANK_CYCLES cycles, then enters SHOW of the next row. This is the anti-ghosting gap.
  - The prefetch has already completed during SHOW.
- Undefined: no BLANK state. The next row becomes lit on the cycle after d=DWELL_CYCLES-1, with zero dark cycles between rows.

## Test plan
- Reset, then release rst with scan_en=0 for 20 clocks -> every output holds its reset value; ram_addr_row=ram_addr_col=8'h01.
- DWELL=16, buffer all 0 except ram[2][5]=4'b1010, scan_en=1 ->
  - row_on=8'h04 appears exactly 10+2×16 clocks after enable (macro off).
  - During that row col_r=8'h20 and col_g=0; all other rows are lit with col_r=col_g=0.
- ram[0][0]=4'b0110 (stored bit clear) and ram[0][1]=4'b1100 -> row 0 shows col_r=0, col_g=8'h02.
- DWELL=16, macro off, free run for 3 frames -> frame_start pulses every 128 clocks; row_on sequence is 01,02,…,80,01; never 0 between rows.
- With LED_SCAN_BLANK_EN and BLANK=4 -> row_on=0 for exactly 4 clocks between rows; frame_start period is 160 clocks.
- Drop scan_en at d=5 of row 3, re-raise after 7 clocks -> next cycle dark; on re-enable row 0 is lit after 10 clocks with frame_start=1.
